// File: rtl/bk_pkg.sv
// Shared constants for the Brent-Kung adder tile: default operand width and
// where the sum and carry-out land on uo_out.
package bk_pkg;
    localparam int WIDTH    = 4;
    localparam int LOG2W    = 2;
    localparam int SUM_LSB  = 0;
    localparam int COUT_BIT = 4;
endpackage

// File: rtl/bk_black_cell.sv
// Prefix-tree black cell: merges a higher group (g_hi,p_hi) with the adjacent
// lower group (g_lo,p_lo) into one combined generate/propagate pair.
module bk_black_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);
    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;
endmodule

// File: rtl/tt_um_brent_kung.sv
// Tiny Tapeout tile: A + B + cin through a Brent-Kung prefix tree, with an
// optional output register on clk.
module tt_um_brent_kung
    import bk_pkg::*;
#(
    parameter int WIDTH           = bk_pkg::WIDTH,
    parameter bit REGISTER_OUTPUT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int LW     = $clog2(WIDTH);
    localparam int NLEV   = (LW == 0) ? 0 : 2 * LW - 1;
    localparam int CO_POS = COUT_BIT - bk_pkg::WIDTH + WIDTH;

    logic [WIDTH-1:0] a, b, g, p, sum;
    logic             cin;
    logic [WIDTH:0]   c;
    logic [7:0]       uo_next;

    assign a   = ui_in[WIDTH-1:0];
    assign b   = uio_in[WIDTH-1:0];
    assign cin = ui_in[4];
    assign g   = a & b;
    assign p   = a ^ b;

    // Level 0 folds cin into bit 0, so every tree output is already the
    // carry out of that position: C_i = G[i:-1].
    // Levels 1..LW are the up-sweep (span 2^L), the rest the down-sweep.
    for (genvar L = 0; L <= NLEV; L++) begin : g_lvl
        logic [WIDTH-1:0] gg, pp;
        for (genvar I = 0; I < WIDTH; I++) begin : g_bit
            if (L == 0) begin : g_pre
                if (I == 0) begin : g_cin
                    bk_black_cell u_cell (
                        .g_hi(g[0]), .p_hi(p[0]), .g_lo(cin), .p_lo(1'b0),
                        .g(gg[0]), .p(pp[0])
                    );
                end else begin : g_pass
                    assign gg[I] = g[I];
                    assign pp[I] = p[I];
                end
            end else begin : g_tree
                localparam bit UP   = (L <= LW);
                localparam int SPAN = UP ? (1 << L) : (1 << (2 * LW - L));
                localparam bit COMB = UP ? (((I + 1) % SPAN) == 0)
                                         : ((((I + 1) % SPAN) == SPAN / 2) && (I >= SPAN));
                localparam int LO   = I - SPAN / 2;
                if (COMB) begin : g_cell
                    bk_black_cell u_cell (
                        .g_hi(g_lvl[L-1].gg[I]),  .p_hi(g_lvl[L-1].pp[I]),
                        .g_lo(g_lvl[L-1].gg[LO]), .p_lo(g_lvl[L-1].pp[LO]),
                        .g(gg[I]), .p(pp[I])
                    );
                end else begin : g_pass
                    assign gg[I] = g_lvl[L-1].gg[I];
                    assign pp[I] = g_lvl[L-1].pp[I];
                end
            end
        end
    end

    assign c[0]       = cin;
    assign c[WIDTH:1] = g_lvl[NLEV].gg;
    assign sum        = p ^ c[WIDTH-1:0];

    always_comb begin
        uo_next                    = '0;
        uo_next[SUM_LSB +: WIDTH]  = sum;
        uo_next[CO_POS]            = c[WIDTH];
    end

    if (REGISTER_OUTPUT) begin : g_reg
        logic [7:0] uo_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) uo_q <= '0;
            else        uo_q <= uo_next;
        end
        assign uo_out = uo_q;
    end else begin : g_comb
        assign uo_out = uo_next;
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

    // Pins the harness provides but this tile does not need in every build.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, clk, rst_n, ui_in, uio_in, g_lvl[NLEV].pp};
endmodule

// File: tb/tb_tt_um_brent_kung.sv
// Directed checks for the combinational and registered builds of the tile.
module tb_tt_um_brent_kung;
    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_c, uio_out_c, uio_oe_c;
    logic [7:0] uo_r, uio_out_r, uio_oe_r;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    tt_um_brent_kung #(.WIDTH(4), .REGISTER_OUTPUT(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_c), .uio_out(uio_out_c), .uio_oe(uio_oe_c)
    );

    tt_um_brent_kung #(.WIDTH(4), .REGISTER_OUTPUT(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_r), .uio_out(uio_out_r), .uio_oe(uio_oe_r)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        chk("zero_comb",    uo_c,      8'h00);
        chk("zero_uio_out", uio_out_c, 8'h00);
        chk("zero_uio_oe",  uio_oe_c,  8'h00);
        chk("rst_reg",      uo_r,      8'h00);
        chk("rst_uio_oe_r", uio_oe_r,  8'h00);
        chk("rst_uio_out_r", uio_out_r, 8'h00);

        ui_in = 8'h03; #1;
        chk("3plus0", uo_c, 8'h03);
        uio_in = 8'h01; #1;
        chk("3plus1", uo_c, 8'h04);

        // Registered build held in reset across clock edges
        @(posedge clk); @(posedge clk); #1;
        chk("rst_hold_reg", uo_r, 8'h00);

        @(negedge clk); rst_n = 1'b1; #1;
        chk("rel_no_edge", uo_r, 8'h00);
        @(posedge clk); #1;
        chk("rel_first_edge", uo_r, 8'h04);

        @(negedge clk); ui_in = 8'h1F; uio_in = 8'h0F; #1;
        chk("max_comb",     uo_c, 8'h1F);
        chk("max_reg_hold", uo_r, 8'h04);
        @(posedge clk); #1;
        chk("max_reg", uo_r, 8'h1F);

        @(negedge clk); ui_in = 8'h0F; uio_in = 8'h01; ena = 1'b0; #1;
        chk("cout_comb", uo_c, 8'h10);
        @(posedge clk); #1;
        chk("cout_reg", uo_r, 8'h10);

        // Asynchronous reset assertion between edges
        @(posedge clk); #2; rst_n = 1'b0; #1;
        chk("async_rst", uo_r, 8'h00);
        chk("async_rst_comb", uo_c, 8'h10);
        @(negedge clk); rst_n = 1'b1; ena = 1'b1;

        // Exhaustive sweep, clean then with junk on the ignored pins
        for (int pass = 0; pass < 2; pass++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    for (int ci = 0; ci < 2; ci++) begin
                        @(negedge clk);
                        ui_in  = {3'b000, 1'(ci), 4'(a)};
                        uio_in = {4'b0000, 4'(b)};
                        if (pass == 1) begin
                            ui_in[7:5]  = 3'($urandom_range(0, 7));
                            uio_in[7:4] = 4'($urandom_range(0, 15));
                            ena         = 1'($urandom_range(0, 1));
                        end
                        exp = 8'(a + b + ci);
                        #1;
                        chk(pass == 0 ? "sweep_comb" : "sweep_comb_junk", uo_c, exp);
                        @(posedge clk); #1;
                        chk(pass == 0 ? "sweep_reg" : "sweep_reg_junk", uo_r, exp);
                    end
                end
            end
        end

        chk("end_uio_oe_r",  uio_oe_r,  8'h00);
        chk("end_uio_out_c", uio_out_c, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
